// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sharing arbiter: control codes, legality check, FSM states.
package alu_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b100;
    localparam logic [2:0] ALU_MUL = 3'b101;
    localparam logic [2:0] ALU_SLT = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_RESP
    } state_t;

    // Codes 011 and 111 have no ALU operation behind them.
    function automatic logic ctrl_legal(input logic [2:0] ctrl);
        case (ctrl)
            ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_MUL, ALU_SLT: return 1'b1;
            default:                                             return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: on contention the port not granted last wins.
module rr_arb2 (
    input  logic       req0,
    input  logic       req1,
    input  logic       last,
    output logic [1:0] grant
);

    always_comb begin
        // NOTE: grant gets a default first so every path assigns it and no latch is inferred.
        grant = 2'b00;
        if (req0 && req1)
            grant = last ? 2'b01 : 2'b10;
        else if (req0)
            grant = 2'b01;
        else if (req1)
            grant = 2'b10;
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one external ALU between two requesters; one operation in flight, result held until consumed.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [N-1:0] req0_a,
    input  logic [N-1:0] req0_b,
    input  logic [2:0]   req0_ctrl,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [N-1:0] req1_a,
    input  logic [N-1:0] req1_b,
    input  logic [2:0]   req1_ctrl,
    output logic [N-1:0] alu_srca,
    output logic [N-1:0] alu_srcb,
    output logic [2:0]   alu_ctrl,
    input  logic [N-1:0] alu_result,
    input  logic         alu_zero,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [N-1:0] rsp_result,
    output logic         rsp_zero,
    output logic         rsp_err,
    output logic         busy
);

    state_t       state, state_next;
    logic         last_grant;
    logic [1:0]   grant;
    logic         accept;
    logic [N-1:0] op_a, op_b;
    logic [2:0]   op_ctrl;
    logic         op_id;

    rr_arb2 u_arb (
        .req0  (req0_valid),
        .req1  (req1_valid),
        .last  (last_grant),
        .grant (grant)
    );

    assign accept = (req0_valid & req0_ready) | (req1_valid & req1_ready);

    always_comb begin
        state_next = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        alu_srca   = '0;
        alu_srcb   = '0;
        alu_ctrl   = 3'b000;
        rsp_valid  = 1'b0;
        busy       = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                // Readies stay low while reset is held even though the arbiter is combinational.
                req0_ready = grant[0] & ~rst;
                req1_ready = grant[1] & ~rst;
                if (accept)
                    state_next = ST_EXEC;
            end
            ST_EXEC: begin
                alu_srca   = op_a;
                alu_srcb   = op_b;
                alu_ctrl   = op_ctrl;
                state_next = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready)
                    state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            last_grant <= 1'b1;
            op_a       <= '0;
            op_b       <= '0;
            op_ctrl    <= 3'b000;
            op_id      <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
            rsp_err    <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout so every register samples the pre-edge values.
            state <= state_next;
            if (accept) begin
                last_grant <= req1_ready;
                op_id      <= req1_ready;
                op_a       <= req1_ready ? req1_a    : req0_a;
                op_b       <= req1_ready ? req1_b    : req0_b;
                op_ctrl    <= req1_ready ? req1_ctrl : req0_ctrl;
            end
            if (state == ST_EXEC) begin
                rsp_id <= op_id;
                if (ctrl_legal(op_ctrl)) begin
                    rsp_result <= alu_result;
                    rsp_zero   <= alu_zero;
                    rsp_err    <= 1'b0;
                end else begin
                    rsp_result <= '0;
                    rsp_zero   <= 1'b1;
                    rsp_err    <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/alu_share_arbiter.md
ALU_SHARE_ARBITER -- requirements
Module: alu_share_arbiter

Interface
REQ-001 Parameter N, default 32: operand and result width.
REQ-002 clk  in  1  single clock for all state; rising-edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 req0_valid / req1_valid  in  1  each: requester 0/1 has an operation pending.
REQ-005 req0_ready / req1_ready  out  1  each: request accepted this cycle when valid&ready.
REQ-006 req0_a, req0_b / req1_a, req1_b  in  N  each: operands SrcA, SrcB.
REQ-007 req0_ctrl / req1_ctrl  in  3  each: ALU control code.
REQ-008 alu_srca, alu_srcb  out  N  operands driven to the shared ALU.
REQ-009 alu_ctrl  out  3  control code driven to the shared ALU.
REQ-010 alu_result  in  N  ALU result.
REQ-011 alu_zero  in  1  ALU zero flag.
REQ-012 rsp_valid  out  1  response held for the consumer.
REQ-013 rsp_ready  in  1  consumer accepts the response when rsp_valid&rsp_ready.
REQ-014 rsp_id  out  1  requester that owns the response (0/1).
REQ-015 rsp_result  out  N  registered result.
REQ-016 rsp_zero  out  1  registered zero flag.
REQ-017 rsp_err  out  1  illegal control code flag.
REQ-018 busy  out  1  high in any state other than IDLE.

Function
REQ-019 FSM states: IDLE, EXEC, RESP; one operation in flight at a time.
REQ-020 IDLE: grant chosen combinationally; only the granted port's ready is high; both readies low in EXEC and RESP.
REQ-021 Arbitration: one valid requester wins; if both are valid, the port not granted last wins; the last-grant pointer updates only on an accepted handshake.
REQ-022 Handshake at edge T in IDLE: latch a, b, ctrl and id into operand registers; go to EXEC.
REQ-023 EXEC (one cycle): alu_srca/alu_srcb/alu_ctrl driven from the operand registers; at cycle end capture alu_result and alu_zero into rsp registers; go to RESP.
REQ-024 Legal codes: 000 AND, 001 OR, 010 ADD, 100 SUB, 101 MUL (low N bits), 110 SLT (unsigned).
REQ-025 Codes 011 and 111: rsp_err=1, rsp_result=0, rsp_zero=1; otherwise rsp_err=0.
REQ-026 Latency: rsp_valid rises in cycle T+2 after the accepting edge T.
REQ-027 RESP: rsp_valid=1; rsp_id/result/zero/err remain stable until the handshake; on rsp_valid&rsp_ready go to IDLE.
REQ-028 Throughput: a new request cannot be accepted before the IDLE cycle that follows the response handshake (at most one op per 3 cycles).
REQ-029 Outside EXEC, alu_srca, alu_srcb and alu_ctrl are driven to 0.
REQ-030 A requester dropping valid while not granted has no effect; requests are never reordered within a port.

Reset
REQ-031 rst asserted at any time, including mid-operation, immediately returns the FSM to IDLE and discards any in-flight operation or held response.
REQ-032 Reset values: ready=0 pending grant logic, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_zero=0, rsp_err=0, busy=0, ALU outputs 0.
REQ-033 Last-grant pointer resets to 1, so port 0 wins the first contention.

Structure
REQ-034 Shared package alu_pkg holds the ALU control code constants, the legal-code check function and the FSM state enumeration.
REQ-035 Two-way round-robin arbitration is a sub-module rr_arb2 (inputs: two requests, pointer; output: one-hot grant).
REQ-036 The ALU is instantiated outside this block; the block holds no arithmetic.

Verification
REQ-037 Scenario: reset, then req0 ADD a=5 b=7 -> accepted at T; rsp_valid at T+2; id=0, result=12, zero=0, err=0.
REQ-038 Scenario: req0 and req1 valid in the same cycle after reset -> port 0 granted first, then port 1; with both held continuously, grants alternate 0,1,0,1.
REQ-039 Scenario: req1 SUB a=9 b=9 with rsp_ready low for 4 cycles -> rsp held stable (result=0, zero=1) for all 4 cycles; both readies low throughout.
REQ-040 Scenario: ctrl=011 with a=3 b=4 -> err=1, result=0, zero=1; ctrl=101 with a=0x10000 b=0x10000 -> result=0, zero=1 (low 32 bits).
REQ-041 Scenario: rst pulsed during EXEC -> rsp_valid never asserts for that operation; busy=0; next request completes normally.
REQ-042 Scenario: SLT with a=2 b=3 -> result=1; a=3 b=2 -> result=0, zero=1.
